// File: rtl/chip_sequencer.sv
// Chip/bit sequencer for the DCSK transmitter serializer.
// Define CHIP_SEQ_GUARD_EN to insert GUARD_CHIPS guard cycles between the last chip and o_done.
module chip_sequencer #(
    parameter int unsigned MAX_SF_LOG2 = 4,
    parameter int unsigned FRAME_W     = 10,
    parameter int unsigned GUARD_CHIPS = 8,
    localparam int unsigned SF_W       = $clog2(MAX_SF_LOG2 + 1),
    localparam int unsigned CW         = MAX_SF_LOG2 + 1
) (
    input  logic               i_clk,
    input  logic               i_arst_n,
    input  logic               i_send,
    input  logic               i_abort,
    input  logic [SF_W-1:0]    i_sf_log2,
    input  logic [FRAME_W-1:0] i_frame_len,
    input  logic               i_chaos_valid,
    output logic               o_chaos_ready,
    output logic               o_chip_fire,
    output logic [CW-1:0]      o_chip_index,
    output logic               o_msb,
    output logic               o_load_bit,
    output logic [FRAME_W-1:0] o_bit_index,
    output logic               o_sending,
    output logic               o_done
);

`ifdef CHIP_SEQ_GUARD_EN
    localparam int unsigned GW = $clog2(GUARD_CHIPS + 1);
    typedef enum logic [1:0] {StIdle, StRun, StGuard, StDone} state_t;
`else
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;
`endif

    state_t             r_state, w_state_d;
    logic [SF_W-1:0]    r_sf, w_sf_d;
    logic [FRAME_W-1:0] r_len, w_len_d;
    logic [CW-1:0]      r_chip, w_chip_d;
    logic [FRAME_W-1:0] r_bit, w_bit_d;
    logic [SF_W-1:0]    w_sf_clamped;
    logic [CW-1:0]      w_last_chip;
`ifdef CHIP_SEQ_GUARD_EN
    logic [GW-1:0]      r_guard, w_guard_d;
`else
    // GUARD_CHIPS has no effect unless the guard build is selected.
    if (GUARD_CHIPS == 0) begin : g_no_guard
    end
`endif

    always_comb begin
        w_sf_clamped = i_sf_log2;
        if (i_sf_log2 == '0) begin
            w_sf_clamped = SF_W'(1);
        end else if (i_sf_log2 > SF_W'(MAX_SF_LOG2)) begin
            w_sf_clamped = SF_W'(MAX_SF_LOG2);
        end
    end

    // 2^(sf+1) chips per bit: the last chip index has bits 0..sf set.
    always_comb begin
        w_last_chip = '0;
        for (int i = 0; i < int'(CW); i++) begin
            w_last_chip[i] = (i <= int'(r_sf));
        end
    end

    assign o_chaos_ready = (r_state == StRun);
    assign o_chip_fire   = o_chaos_ready & i_chaos_valid;
    assign o_chip_index  = r_chip;
    assign o_msb         = r_chip[r_sf];
    assign o_load_bit    = o_chip_fire & (r_chip == w_last_chip);
    assign o_bit_index   = r_bit;
    assign o_done        = (r_state == StDone);
`ifdef CHIP_SEQ_GUARD_EN
    assign o_sending     = (r_state == StRun) || (r_state == StGuard);
`else
    assign o_sending     = (r_state == StRun);
`endif

    always_comb begin
        w_state_d = r_state;
        w_sf_d    = r_sf;
        w_len_d   = r_len;
        w_chip_d  = r_chip;
        w_bit_d   = r_bit;
`ifdef CHIP_SEQ_GUARD_EN
        w_guard_d = r_guard;
`endif
        if (i_abort) begin
            w_state_d = StIdle;
            w_chip_d  = '0;
            w_bit_d   = '0;
`ifdef CHIP_SEQ_GUARD_EN
            w_guard_d = '0;
`endif
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_send) begin
                        w_state_d = StRun;
                        w_sf_d    = w_sf_clamped;
                        w_len_d   = i_frame_len;
                        w_chip_d  = '0;
                        w_bit_d   = '0;
                    end
                end
                StRun: begin
                    if (o_chip_fire) begin
                        if (o_load_bit) begin
                            w_chip_d = '0;
                            if (r_bit == r_len) begin
                                w_bit_d = '0;
`ifdef CHIP_SEQ_GUARD_EN
                                w_state_d = StGuard;
                                w_guard_d = '0;
`else
                                w_state_d = StDone;
`endif
                            end else begin
                                w_bit_d = r_bit + FRAME_W'(1);
                            end
                        end else begin
                            w_chip_d = r_chip + CW'(1);
                        end
                    end
                end
`ifdef CHIP_SEQ_GUARD_EN
                StGuard: begin
                    if (r_guard == GW'(GUARD_CHIPS - 1)) begin
                        w_state_d = StDone;
                        w_guard_d = '0;
                    end else begin
                        w_guard_d = r_guard + GW'(1);
                    end
                end
`endif
                StDone:  w_state_d = StIdle;
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state <= StIdle;
            r_sf    <= '0;
            r_len   <= '0;
            r_chip  <= '0;
            r_bit   <= '0;
`ifdef CHIP_SEQ_GUARD_EN
            r_guard <= '0;
`endif
        end else begin
            r_state <= w_state_d;
            r_sf    <= w_sf_d;
            r_len   <= w_len_d;
            r_chip  <= w_chip_d;
            r_bit   <= w_bit_d;
`ifdef CHIP_SEQ_GUARD_EN
            r_guard <= w_guard_d;
`endif
        end
    end

endmodule

// File: tb/tb_chip_sequencer.sv
// Bench for chip_sequencer: a table of frames checked against an expected-chip queue,
// plus hand-written reset and abort sequences.
module tb_chip_sequencer;

    localparam int unsigned MAX_SF_LOG2 = 4;
    localparam int unsigned FRAME_W     = 10;
    localparam int unsigned GUARD_CHIPS = 8;
`ifdef CHIP_SEQ_GUARD_EN
    localparam int GUARD_DELAY = 8;
`else
    localparam int GUARD_DELAY = 0;
`endif
    localparam int BUDGET = 4000;

    logic               i_clk = 1'b0;
    logic               i_arst_n = 1'b0;
    logic               i_send = 1'b0;
    logic               i_abort = 1'b0;
    logic [2:0]         i_sf_log2 = '0;
    logic [FRAME_W-1:0] i_frame_len = '0;
    logic               i_chaos_valid = 1'b0;
    logic               o_chaos_ready;
    logic               o_chip_fire;
    logic [4:0]         o_chip_index;
    logic               o_msb;
    logic               o_load_bit;
    logic [FRAME_W-1:0] o_bit_index;
    logic               o_sending;
    logic               o_done;

    chip_sequencer #(
        .MAX_SF_LOG2 (MAX_SF_LOG2),
        .FRAME_W     (FRAME_W),
        .GUARD_CHIPS (GUARD_CHIPS)
    ) u_dut (
        .i_clk         (i_clk),
        .i_arst_n      (i_arst_n),
        .i_send        (i_send),
        .i_abort       (i_abort),
        .i_sf_log2     (i_sf_log2),
        .i_frame_len   (i_frame_len),
        .i_chaos_valid (i_chaos_valid),
        .o_chaos_ready (o_chaos_ready),
        .o_chip_fire   (o_chip_fire),
        .o_chip_index  (o_chip_index),
        .o_msb         (o_msb),
        .o_load_bit    (o_load_bit),
        .o_bit_index   (o_bit_index),
        .o_sending     (o_sending),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]         sf_in;
        logic [FRAME_W-1:0] len;
        int                 sf_eff;     // expected spreading exponent after clamping
        bit                 toggle;     // chaos_valid toggles every cycle
        bit                 send_mid;   // i_send pulsed while running
        bit                 change_mid; // sf/len inputs changed while running
    } vec_t;

    typedef struct {
        int chip;
        bit msb;
        bit load;
        int bit_idx;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, int'(o_chaos_ready), 0);
        check({tag, "_fire"}, int'(o_chip_fire), 0);
        check({tag, "_chip"}, int'(o_chip_index), 0);
        check({tag, "_msb"}, int'(o_msb), 0);
        check({tag, "_load"}, int'(o_load_bit), 0);
        check({tag, "_bit"}, int'(o_bit_index), 0);
        check({tag, "_sending"}, int'(o_sending), 0);
        check({tag, "_done"}, int'(o_done), 0);
    endtask

    // Starts at posedge+1 in IDLE; returns at posedge+1 in IDLE after the frame.
    task automatic run_frame(input vec_t v);
        int   cpb;
        int   cyc;
        int   end_cyc;
        int   exp_ready;
        exp_t e;
        cpb = 1 << (v.sf_eff + 1);
        for (int b = 0; b <= int'(v.len); b++) begin
            for (int c = 0; c < cpb; c++) begin
                e.chip    = c;
                e.msb     = (c >= cpb / 2);
                e.load    = (c == cpb - 1);
                e.bit_idx = b;
                exp_q.push_back(e);
            end
        end
        i_sf_log2   = v.sf_in;
        i_frame_len = v.len;
        i_send      = 1'b1;
        @(posedge i_clk);
        #1;
        i_send  = 1'b0;
        cyc     = 0;
        end_cyc = -1;
        while ((end_cyc < 0 || cyc <= end_cyc + 2 + GUARD_DELAY) && cyc < BUDGET) begin
            i_chaos_valid = v.toggle ? (cyc % 2 == 0) : 1'b1;
            i_send        = v.send_mid && (cyc == 2 || cyc == 3);
            if (v.change_mid && cyc == 3) begin
                i_sf_log2   = v.sf_in ^ 3'd3;
                i_frame_len = v.len + FRAME_W'(5);
            end
            @(negedge i_clk);
            exp_ready = (exp_q.size() != 0) ? 1 : 0;
            check("ready", int'(o_chaos_ready), exp_ready);
            check("fire", int'(o_chip_fire), (exp_ready != 0 && i_chaos_valid) ? 1 : 0);
            check("sending", int'(o_sending),
                  (exp_ready != 0 || (end_cyc >= 0 && cyc < end_cyc + 1 + GUARD_DELAY)) ? 1 : 0);
            check("done", int'(o_done), (end_cyc >= 0 && cyc == end_cyc + 1 + GUARD_DELAY) ? 1 : 0);
            if (o_chip_fire && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("chip_index", int'(o_chip_index), e.chip);
                check("msb", int'(o_msb), int'(e.msb));
                check("load_bit", int'(o_load_bit), int'(e.load));
                check("bit_index", int'(o_bit_index), e.bit_idx);
                if (exp_q.size() == 0) end_cyc = cyc;
            end else begin
                check("load_nofire", int'(o_load_bit), 0);
                if (exp_ready == 0) check("chip_after_end", int'(o_chip_index), 0);
            end
            @(posedge i_clk);
            #1;
            cyc++;
        end
        i_send = 1'b0;
        check("frame_end_seen", (end_cyc >= 0) ? 1 : 0, 1);
        check("chips_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{3'd1, 10'd2, 1, 1'b0, 1'b0, 1'b0}; // continuous, 4 chips x 3 bits
        vecs[1] = '{3'd4, 10'd1, 4, 1'b1, 1'b0, 1'b0}; // stalls, 32 chips per bit
        vecs[2] = '{3'd0, 10'd1, 1, 1'b0, 1'b0, 1'b0}; // sf 0 clamps to 1
        vecs[3] = '{3'd7, 10'd0, 4, 1'b0, 1'b0, 1'b0}; // sf 7 clamps to 4
        vecs[4] = '{3'd2, 10'd3, 2, 1'b1, 1'b1, 1'b1}; // ignored send, latched sf/len
        vecs[5] = '{3'd3, 10'd0, 3, 1'b0, 1'b0, 1'b0}; // single-bit frame

        // Reset state
        i_arst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_arst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Asynchronous reset in the middle of a frame
        i_sf_log2     = 3'd1;
        i_frame_len   = 10'd3;
        i_chaos_valid = 1'b1;
        i_send        = 1'b1;
        @(posedge i_clk);
        #1;
        i_send = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        check("midrun_sending", int'(o_sending), 1);
        check("midrun_chip", int'(o_chip_index), 1);
        #2;
        i_arst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge i_clk);
        #1;
        i_arst_n = 1'b1;
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        check_all_zero("after_reset");
        @(posedge i_clk);
        #1;

        // Abort at bit 1 chip 5 (sf=2 gives 8 chips per bit), with a simultaneous send
        i_sf_log2     = 3'd2;
        i_frame_len   = 10'd3;
        i_chaos_valid = 1'b1;
        i_send        = 1'b1;
        @(posedge i_clk);
        #1;
        i_send = 1'b0;
        for (int k = 0; k <= 13; k++) begin
            if (k == 13) begin
                i_abort = 1'b1;
                i_send  = 1'b1;
            end
            @(negedge i_clk);
            check("abort_seq_chip", int'(o_chip_index), k % 8);
            check("abort_seq_bit", int'(o_bit_index), k / 8);
            check("abort_seq_fire", int'(o_chip_fire), 1);
            @(posedge i_clk);
            #1;
        end
        i_abort = 1'b0;
        i_send  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            check_all_zero("post_abort");
            @(posedge i_clk);
            #1;
        end

        // Table of frames; each must start fresh at chip 0 bit 0
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
